// File: rtl/eaglesong_circulant_pkg.sv
// eaglesong_pkg: shared sizes, state/FSM types and rotate helper for the circulant step
package eaglesong_pkg;
    localparam int NUM_WORDS = 16;
    localparam int WORD_W = 32;
    localparam int COEFFS_PER_WORD = 3;
    localparam int NUM_COEFFS = 48;
    localparam int COEF_W = 5;
    localparam int IDX_W = 6;

    typedef logic [NUM_WORDS*WORD_W-1:0] state_t;

    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

    // Rotate left: the upper half of the doubled word shifted by c is the rotated word
    function automatic logic [WORD_W-1:0] rotl(input logic [WORD_W-1:0] w, input logic [COEF_W-1:0] c);
        logic [2*WORD_W-1:0] d;
        d = {w, w} << c;
        return d[2*WORD_W-1:WORD_W];
    endfunction
endpackage

// File: rtl/eaglesong_circulant_if.sv
// eaglesong_circulant_if: input/output valid-ready streams of the circulant stage
interface eaglesong_circulant_if;
    import eaglesong_pkg::*;
    logic in_valid;
    logic in_ready;
    state_t state_in;
    logic out_valid;
    logic out_ready;
    state_t state_out;

    modport master (
        output in_valid, state_in, out_ready,
        input in_ready, out_valid, state_out
    );

    modport slave (
        input in_valid, state_in, out_ready,
        output in_ready, out_valid, state_out
    );
endinterface

// File: rtl/eaglesong_circulant_coefficients.sv
// eaglesong_coefficients: combinational ROM of the 48 Eaglesong circulant rotation amounts
module eaglesong_coefficients import eaglesong_pkg::*; (
    input logic [IDX_W-1:0] index_to_request,
    output logic [COEF_W-1:0] requested_coefficient
);
    localparam logic [COEF_W-1:0] ROM [NUM_COEFFS] = '{
        5'd0, 5'd2, 5'd4, 5'd0, 5'd13, 5'd22, 5'd0, 5'd4, 5'd19, 5'd0, 5'd3, 5'd14,
        5'd0, 5'd27, 5'd31, 5'd0, 5'd3, 5'd8, 5'd0, 5'd17, 5'd26, 5'd0, 5'd3, 5'd12,
        5'd0, 5'd18, 5'd22, 5'd0, 5'd12, 5'd18, 5'd0, 5'd4, 5'd7, 5'd0, 5'd4, 5'd31,
        5'd0, 5'd12, 5'd27, 5'd0, 5'd7, 5'd17, 5'd0, 5'd7, 5'd8, 5'd0, 5'd1, 5'd13
    };

    assign requested_coefficient = index_to_request < IDX_W'(NUM_COEFFS) ? ROM[index_to_request] : '0;
endmodule

// File: rtl/eaglesong_circulant.sv
// eaglesong_circulant: walks the 48 ROM coefficients, one per cycle, XOR-ing three rotations per word
module eaglesong_circulant #(
    parameter int NUM_WORDS = 16,
    parameter int WORD_W = 32,
    parameter int DEBUG = 0
) (
    input logic clk,
    input logic reset,
    eaglesong_circulant_if.slave bus,
    output logic busy,
    output logic [eaglesong_pkg::IDX_W-1:0] coef_index
);
    import eaglesong_pkg::*;

    fsm_t state;
    state_t buffer;
    logic [(NUM_WORDS-1)*WORD_W-1:0] result;
    logic [WORD_W-1:0] acc, word, rot, mixed;
    logic [COEF_W-1:0] c;
    logic [3:0] word_idx;
    logic [1:0] slot;
    logic last;

    eaglesong_coefficients rom (
        .index_to_request(coef_index),
        .requested_coefficient(c)
    );

    // word_idx/slot track coef_index/3 and coef_index%3 so no divider is needed
    assign word = buffer[word_idx*WORD_W +: WORD_W];
    assign rot = rotl(word, c);
    assign mixed = acc ^ rot;
    assign last = coef_index == IDX_W'(NUM_COEFFS - 1);

    // Control FSM with registered handshake outputs and the accumulate datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            bus.in_ready <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.state_out <= '0;
            busy <= 1'b0;
            coef_index <= '0;
            word_idx <= '0;
            slot <= '0;
            buffer <= '0;
            result <= '0;
            acc <= '0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid && bus.in_ready) begin
                    buffer <= bus.state_in;
                    coef_index <= '0;
                    word_idx <= '0;
                    slot <= '0;
                    bus.in_ready <= 1'b0;
                    busy <= 1'b1;
                    state <= RUN;
                end
                RUN: begin
                    coef_index <= last ? '0 : coef_index + 1'b1;
                    slot <= slot == 2'd2 ? 2'd0 : slot + 1'b1;
                    word_idx <= slot == 2'd2 ? word_idx + 1'b1 : word_idx;
                    acc <= slot == 2'd0 ? rot : mixed;
                    if (slot == 2'd2 && !last)
                        result[word_idx*WORD_W +: WORD_W] <= mixed;
                    if (last) begin
                        bus.state_out <= {mixed, result};
                        bus.out_valid <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: if (bus.out_ready) begin
                    bus.out_valid <= 1'b0;
                    bus.in_ready <= 1'b1;
                    busy <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Debug builds additionally check that no index beyond the ROM is ever issued
    if (DEBUG != 0) begin : g_check
        assert property (@(posedge clk) disable iff (reset) state == RUN |-> coef_index < IDX_W'(NUM_COEFFS));
    end
endmodule

// File: tb/tb_eaglesong_circulant.sv
// tb_eaglesong_circulant: scoreboard bench with a bit-level circulant reference model
module tb_eaglesong_circulant;
    import eaglesong_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic busy;
    logic [IDX_W-1:0] coef_index;
    int total = 0;
    int bad = 0;
    state_t exp_q[$];

    localparam int COEF [48] = '{0, 2, 4, 0, 13, 22, 0, 4, 19, 0, 3, 14, 0, 27, 31, 0, 3, 8,
                                 0, 17, 26, 0, 3, 12, 0, 18, 22, 0, 12, 18, 0, 4, 7, 0, 4, 31,
                                 0, 12, 27, 0, 7, 17, 0, 7, 8, 0, 1, 13};

    eaglesong_circulant_if bus();

    eaglesong_circulant dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .busy(busy),
        .coef_index(coef_index)
    );

    always #5 clk = ~clk;

    // Each input bit j of word i lands at bit (j+c) mod 32 once per coefficient c of that word
    function automatic state_t model(input state_t s);
        state_t r = '0;
        for (int i = 0; i < 16; i++)
            for (int t = 0; t < 3; t++)
                for (int j = 0; j < 32; j++)
                    r[32*i + (j + COEF[3*i+t]) % 32] ^= s[32*i + j];
        return r;
    endfunction

    function automatic state_t rand_state();
        state_t r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom();
        return r;
    endfunction

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    task automatic send(input state_t s, input state_t want);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.state_in = s;
        @(negedge clk);
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: in_ready never rose");
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        exp_q.push_back(want);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat, output bit ctl_ok);
        lat = 0;
        ctl_ok = 1'b1;
        @(negedge clk);
        while (!bus.out_valid && lat < 100) begin
            if (bus.in_ready || !busy) ctl_ok = 1'b0;
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic run_one(input string name, input state_t s, input state_t want);
        int lat;
        bit ok;
        @(posedge clk);
        #1;
        send(s, want);
        wait_done(lat, ok);
        check({name, "_latency"}, lat, 48);
        check({name, "_ctl"}, ok, 1);
    endtask

    // Monitor: every completed output transfer is compared with the oldest expected result
    initial forever begin
        @(negedge clk);
        if (!reset && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL scoreboard: unexpected output %0h", bus.state_out);
            end else begin
                check("scoreboard", bus.state_out, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        state_t s, e, held;
        int lat, n;
        bit ok;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        bus.state_in = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_coef_index", coef_index, 0);
        check("rst_state_out", bus.state_out, 0);
        @(posedge clk);
        #1 reset = 1'b0;

        run_one("zero", '0, '0);

        s = '0; s[31:0] = 32'h1;
        e = '0; e[31:0] = 32'h15;
        run_one("word0", s, e);

        s = '0; s[4*32 +: 32] = 32'h8000_0000; s[15*32 +: 32] = 32'h1;
        e = '0; e[4*32 +: 32] = 32'hC400_0000; e[15*32 +: 32] = 32'h0000_2003;
        run_one("word4_15", s, e);

        // Back-to-back all-ones: second in_valid rises during DONE and must wait for the drain
        run_one("ones_a", '1, '1);
        send('1, '1);
        wait_done(lat, ok);
        check("ones_b_latency", lat, 48);
        check("ones_b_ctl", ok, 1);

        // Backpressure in DONE with ignored in_valid pulses
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        s = rand_state();
        send(s, model(s));
        wait_done(lat, ok);
        check("hold_latency", lat, 48);
        held = bus.state_out;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            bus.in_valid = k[0];
            bus.state_in = ~s;
            @(negedge clk);
            check("hold_out_valid", bus.out_valid, 1);
            check("hold_state_out", bus.state_out, held);
            check("hold_in_ready", bus.in_ready, 0);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("drain_out_valid", bus.out_valid, 0);
        check("drain_in_ready", bus.in_ready, 1);
        check("drain_busy", busy, 0);

        // Reset at RUN index 20 discards the partial result
        @(posedge clk);
        #1;
        s = rand_state();
        send(s, model(s));
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (coef_index != 6'd20 && n < 100);
        check("mid_run_index", coef_index, 20);
        reset = 1'b1;
        void'(exp_q.pop_back());
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("mid_rst_in_ready", bus.in_ready, 1);
        check("mid_rst_out_valid", bus.out_valid, 0);
        check("mid_rst_coef_index", coef_index, 0);
        check("mid_rst_state_out", bus.state_out, 0);
        check("mid_rst_busy", busy, 0);
        s = rand_state();
        run_one("after_rst", s, model(s));

        for (int k = 0; k < 5; k++) begin
            s = rand_state();
            run_one("random", s, model(s));
        end

        repeat (3) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
